// File: rtl/mem_resp_pkg.sv
// Shared types for the data-side SRAM responder: FSM state encoding and wait-counter width.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/sram_be_array.sv
// Single-port word array with 4 byte-lane write enables; read-old data registered on access.
// Latency: rdata_o updates at the access edge; no backpressure, one access per enabled cycle.
module sram_be_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  acc_i,
  input  logic [3:0]            wen_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  // Contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (acc_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_i[i]) begin
          mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (acc_i) begin
      rdata_q <= mem[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: one access at a time, response WAIT_CYCLES+1 cycles after accept.
// Stalls the pipeline while waiting; the stall drops in the last wait cycle.
module data_sram_resp
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic        stallreq_for_mem
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);
  localparam bit                NO_WAIT   = (WAIT_CYCLES == 0);

  state_e                  state_q, state_d;
  logic [WAIT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]              wen_q, wen_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    accepting;
  logic                    access;
  logic [3:0]              acc_wen;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [31:0]             acc_wdata;
  logic                    unused_addr;

  assign unused_addr = ^{data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};
  assign accepting   = (state_q == IDLE) || (state_q == RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    access  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (data_sram_en) begin
          wen_d   = data_sram_wen;
          idx_d   = data_sram_addr[DEPTH_LOG2+1:2];
          wdata_d = data_sram_wdata;
          if (NO_WAIT) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // en is ignored here: the core keeps presenting the same request while stalled.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WAIT_W'(1)) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Zero-wait accesses use the live request; otherwise the latched copy.
  assign acc_wen   = NO_WAIT ? data_sram_wen                   : wen_q;
  assign acc_idx   = NO_WAIT ? data_sram_addr[DEPTH_LOG2+1:2] : idx_q;
  assign acc_wdata = NO_WAIT ? data_sram_wdata                 : wdata_q;

  sram_be_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (clk),
    .rst_ni (resetn),
    .acc_i  (access && resetn),
    .wen_i  (acc_wen),
    .idx_i  (acc_idx),
    .wdata_i(acc_wdata),
    .rdata_o(data_sram_rdata)
  );

  assign resp_valid       = (state_q == RESP);
  assign stallreq_for_mem = (accepting && data_sram_en && !NO_WAIT) ||
                            ((state_q == BUSY) && (cnt_q > WAIT_W'(1)));

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rd0, rd2, rd3;
  logic        rv0, rv2, rv3;
  logic        st0, st2, st3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_sram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .resetn(resetn), .data_sram_en(en[0]), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd0),
    .resp_valid(rv0), .stallreq_for_mem(st0)
  );

  data_sram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .resetn(resetn), .data_sram_en(en[1]), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd2),
    .resp_valid(rv2), .stallreq_for_mem(st2)
  );

  data_sram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .resetn(resetn), .data_sram_en(en[2]), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd3),
    .resp_valid(rv3), .stallreq_for_mem(st3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv(input logic [2:0] e, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d);
    en    = e;
    wen   = w;
    addr  = a;
    wdata = d;
  endtask

  initial begin
    resetn = 1'b0;
    drv(3'b000, 4'h0, 32'h0, 32'h0);
    tick(); tick(); #1;
    chk("rst_rd0", rd0, 32'h0); chk("rst_rv0", {31'b0, rv0}, 32'h0); chk("rst_st0", {31'b0, st0}, 32'h0);
    chk("rst_rd2", rd2, 32'h0); chk("rst_rv2", {31'b0, rv2}, 32'h0); chk("rst_st2", {31'b0, st2}, 32'h0);
    chk("rst_rd3", rd3, 32'h0); chk("rst_rv3", {31'b0, rv3}, 32'h0); chk("rst_st3", {31'b0, st3}, 32'h0);
    tick(); resetn = 1'b1;

    // Zero-wait write then read of 0x10.
    tick(); drv(3'b001, 4'hF, 32'h10, 32'hDEADBEEF); #1;
    chk("w0_st_T", {31'b0, st0}, 32'h0);
    tick(); drv(3'b001, 4'h0, 32'h10, 32'h0); #1;
    chk("w0_rv_T1", {31'b0, rv0}, 32'h1); chk("w0_st_T1", {31'b0, st0}, 32'h0);
    tick(); drv(3'b000, 4'h0, 32'h0, 32'h0); #1;
    chk("w0_rv_T2", {31'b0, rv0}, 32'h1); chk("w0_rd_T2", rd0, 32'hDEADBEEF);
    chk("w0_st_T2", {31'b0, st0}, 32'h0);
    tick(); #1;
    chk("w0_rv_T3", {31'b0, rv0}, 32'h0); chk("w0_rd_hold", rd0, 32'hDEADBEEF);

    // Two wait states: held write, then back-to-back held read from RESP.
    tick(); drv(3'b010, 4'hF, 32'h10, 32'hCAFEF00D); #1;
    chk("w2_st_T", {31'b0, st2}, 32'h1); chk("w2_rv_T", {31'b0, rv2}, 32'h0);
    tick(); #1;
    chk("w2_st_T1", {31'b0, st2}, 32'h1); chk("w2_rv_T1", {31'b0, rv2}, 32'h0);
    tick(); #1;
    chk("w2_st_T2", {31'b0, st2}, 32'h0); chk("w2_rv_T2", {31'b0, rv2}, 32'h0);
    tick(); drv(3'b010, 4'h0, 32'h10, 32'h0); #1;
    chk("w2_rv_T3", {31'b0, rv2}, 32'h1); chk("b2b_st_accept", {31'b0, st2}, 32'h1);
    tick(); #1;
    chk("b2b_st_1", {31'b0, st2}, 32'h1); chk("b2b_rv_1", {31'b0, rv2}, 32'h0);
    tick(); #1;
    chk("b2b_st_2", {31'b0, st2}, 32'h0); chk("b2b_rv_2", {31'b0, rv2}, 32'h0);
    tick(); drv(3'b000, 4'h0, 32'h0, 32'h0); #1;
    chk("b2b_rv_3", {31'b0, rv2}, 32'h1); chk("b2b_rd", rd2, 32'hCAFEF00D);
    chk("b2b_st_3", {31'b0, st2}, 32'h0);
    tick(); #1;
    chk("b2b_rv_end", {31'b0, rv2}, 32'h0);

    // Byte-lane writes at 0x20 (read-old data returned on each write).
    tick(); drv(3'b001, 4'hF, 32'h20, 32'h11223344);
    tick(); drv(3'b001, 4'h4, 32'h20, 32'hAAAAAAAA);
    tick(); drv(3'b001, 4'h0, 32'h20, 32'h0); #1;
    chk("sb_read_old", rd0, 32'h11223344);
    tick(); drv(3'b001, 4'h3, 32'h20, 32'h55665566); #1;
    chk("sb_result", rd0, 32'h11AA3344);
    tick(); drv(3'b001, 4'h0, 32'h20, 32'h0); #1;
    chk("sh_read_old", rd0, 32'h11AA3344);
    tick(); drv(3'b000, 4'h0, 32'h0, 32'h0); #1;
    chk("sh_result", rd0, 32'h11AA5566);

    // Aliasing: 0x1004 and 0x0006 map to the same word.
    tick(); drv(3'b001, 4'hF, 32'h1004, 32'h12345678);
    tick(); drv(3'b001, 4'h0, 32'h0006, 32'h0);
    tick(); drv(3'b000, 4'h0, 32'h0, 32'h0); #1;
    chk("alias_rd", rd0, 32'h12345678);

    // Three wait states: establish a prior value at 0x40.
    tick(); drv(3'b100, 4'hF, 32'h40, 32'h0BADCAFE); #1;
    chk("w3_st_T", {31'b0, st3}, 32'h1);
    tick(); #1; chk("w3_st_T1", {31'b0, st3}, 32'h1);
    tick(); #1; chk("w3_st_T2", {31'b0, st3}, 32'h1);
    tick(); #1; chk("w3_st_T3", {31'b0, st3}, 32'h0);
    tick(); drv(3'b000, 4'h0, 32'h0, 32'h0); #1;
    chk("w3_rv_T4", {31'b0, rv3}, 32'h1);
    tick(); #1; chk("w3_rv_T5", {31'b0, rv3}, 32'h0);

    // Reset in T+2 of a write: the write must be abandoned.
    tick(); drv(3'b100, 4'hF, 32'h40, 32'hFFFFFFFF);
    tick();
    tick(); resetn = 1'b0; drv(3'b000, 4'h0, 32'h0, 32'h0); #1;
    chk("mid_rst_rd", rd3, 32'h0); chk("mid_rst_rv", {31'b0, rv3}, 32'h0);
    chk("mid_rst_st", {31'b0, st3}, 32'h0);
    tick(); tick(); resetn = 1'b1;
    tick(); drv(3'b100, 4'h0, 32'h40, 32'h0);
    tick(); tick(); tick();
    tick(); drv(3'b000, 4'h0, 32'h0, 32'h0); #1;
    chk("post_rst_rv", {31'b0, rv3}, 32'h1);
    chk("post_rst_rd", rd3, 32'h0BADCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Data-memory responder on the data-side SRAM port driven by the EX stage. Accepts one request at a time (read or byte-masked write), adds a programmable number of wait states, and returns read data with a one-cycle valid pulse. While a wait is in progress it stalls the pipeline. It replaces the zero-wait SRAM model so the stall path can be exercised.

## Interface
- `DEPTH_LOG2`, default 10: memory depth in 32-bit words, 2**DEPTH_LOG2.
- `WAIT_CYCLES`, default 2: extra wait states per access, 0..15.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `data_sram_en`  in  1: request strobe, already masked by the core on flush/exception.
- `data_sram_wen`  in  4: byte write enables, bit i for byte lane i; 0 means read.
- `data_sram_addr`  in  32: byte address.
- `data_sram_wdata`  in  32: write data, already replicated per lane by the core.
- `data_sram_rdata`  out  32: registered read data.
- `resp_valid`  out  1: one-cycle pulse; the access has completed and `data_sram_rdata` holds its result.
- `stallreq_for_mem`  out  1: combinational stall request to the pipeline controller.

## Operation
- States: IDLE, BUSY, RESP. Encoding comes from the shared package.
- Accepting state is IDLE or RESP. With `data_sram_en`=1 in an accepting state:
  - Latch wen, index = `addr[DEPTH_LOG2+1:2]`, and wdata.
  - `addr[1:0]` and address bits above the index are ignored: aligned, aliasing wrap.
- If WAIT_CYCLES=0: the access is performed at that same edge and the next state is RESP.
- If WAIT_CYCLES>0:
  - Counter `cnt` is loaded with WAIT_CYCLES and the next state is BUSY.
  - In BUSY, `cnt` decrements each cycle.
  - At the edge ending the cycle with `cnt`=1, perform the access and go to RESP.
- In BUSY, `data_sram_en` is ignored. The core holds the same request while stalled, so the access is not re-accepted.
- Access semantics:
  - `data_sram_rdata` is loaded with the stored word before any write (read-old).
  - Then each byte lane i with wen[i]=1 is overwritten with wdata[8i+7:8i].
- RESP lasts one cycle with `resp_valid`=1. It then returns to IDLE, or goes to BUSY/RESP if a new request is accepted in that cycle (back-to-back).
- `stallreq_for_mem` = (accepting state & en & WAIT_CYCLES≠0) | (BUSY & cnt>1).
  - It is low in the final BUSY cycle, so the core advances exactly when the data lands.
- `data_sram_rdata` holds its value until the next completed access.

## Timing
- Request accepted in cycle T; response (`resp_valid`=1, rdata valid) in cycle T+1+WAIT_CYCLES.
- The stall is high in cycles T..T+WAIT_CYCLES-1 and low in cycle T+WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+1 cycles.
- Reset values: state IDLE, `cnt`=0, `data_sram_rdata`=0, `resp_valid`=0, `stallreq_for_mem`=0.
- Memory contents are not reset.
- Reset asserted mid-access: the access is abandoned, no write is performed, and all outputs return to reset values immediately (asynchronous).
- A write whose completion edge coincides with reset assertion does not happen.
- `en` with wen=4'b0000 is a pure read. The core never presents a partial byte mask with en=0; wen is ignored when en=0.

## Structure
- Shared package `mem_resp_pkg`:
  - state enum (IDLE=2'd0, BUSY=2'd1, RESP=2'd2)
  - `WAIT_W`=4 counter width constant
- Sub-module `sram_be_array`: single-port, synchronous read-old, 4-lane byte-write word array, parameterised by DEPTH_LOG2. The FSM, counter and stall logic stay in the top.

## Test plan
- WAIT_CYCLES=0: write 0xDEADBEEF, wen=1111, addr 0x10 in cycle T; read 0x10 in T+1 → `resp_valid` every cycle, read returns 0xDEADBEEF in T+2, stall never high.
- WAIT_CYCLES=2: read addr 0x10 held while stalled → stall high in T and T+1, low in T+2; `resp_valid` only in T+3; exactly one access.
- Byte lanes: word 0x11223344 at 0x20; sb-style write wen=0100, wdata=0xAAAAAAAA; then read → 0x11AA3344. sh-style wen=0011, wdata=0x55665566 → 0x11AA5566.
- Aliasing: DEPTH_LOG2=10; write 0x12345678 to 0x1004, read 0x0006 → 0x12345678 (addr[1:0] ignored, wrap at 4 KiB).
- Reset mid-access: WAIT_CYCLES=3, write 0xFFFFFFFF to 0x40, pull `resetn` low in T+2 → outputs zero at once; a later read of 0x40 returns the prior value, not 0xFFFFFFFF.
- Back-to-back from RESP: new request in the RESP cycle → accepted; its stall is asserted in that same cycle; the second response arrives at the correct latency.
